// File: rtl/izh_pkg.sv
// izh_pkg -- shared definitions for the Izhikevich parameter load link.
//
// Holds the serializer state encoding, the parameter geometry (four 8-bit
// parameters a, b, c, d) and the frame-length helper. The frame length
// depends on whether an even-parity bit follows each parameter byte, which
// is selected by the IZH_SER_PARITY_EN macro in the serializer.
package izh_pkg;

    localparam int IZH_PARAM_W        = 8;
    localparam int IZH_NUM_PARAMS     = 4;
    localparam int IZH_DATA_BITS      = IZH_PARAM_W * IZH_NUM_PARAMS;
    localparam int IZH_MAX_FRAME_BITS = (IZH_PARAM_W + 1) * IZH_NUM_PARAMS;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_SHIFT    = 2'd1,
        ST_WAIT_ACK = 2'd2,
        ST_DONE     = 2'd3
    } izh_ser_state_t;

    // Number of serial bit periods in one frame.
    function automatic int izh_frame_bits(input bit parity_en);
        return parity_en ? IZH_MAX_FRAME_BITS : IZH_DATA_BITS;
    endfunction

endpackage

// File: rtl/izh_bit_timer.sv
// izh_bit_timer -- bit-period down-counter shared by the serial link ends.
//
// Holds every serial bit for BIT_DIV enabled cycles. While run is high the
// counter counts down; when it reaches zero bit_tick pulses for one cycle,
// the counter reloads and bit_idx advances. load (re)starts a frame at bit 0.
//
// Ports:
//   clk      in   system clock
//   reset    in   asynchronous active-high reset
//   enable   in   clock enable; low freezes the counter and index
//   load     in   restart the bit period at bit index 0
//   run      in   count while high
//   bit_tick out  one-cycle pulse in the last cycle of each bit period
//   bit_idx  out  index of the bit currently on the line (0-based)
module izh_bit_timer #(
    parameter int BIT_DIV = 4,
    parameter int IDX_W   = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             load,
    input  logic             run,
    output logic             bit_tick,
    output logic [IDX_W-1:0] bit_idx
);

    localparam int             CNT_W  = 8;
    localparam logic [CNT_W-1:0] DIV_M1 = CNT_W'(BIT_DIV - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;

    assign bit_tick = enable && run && !load && (cnt_q == '0);
    assign bit_idx  = idx_q;

    always_comb begin
        cnt_d = cnt_q;
        idx_d = idx_q;
        if (enable) begin
            if (load) begin
                cnt_d = DIV_M1;
                idx_d = '0;
            end else if (run) begin
                if (cnt_q == '0) begin
                    cnt_d = DIV_M1;
                    idx_d = idx_q + IDX_W'(1);
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
            idx_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            idx_q <= idx_d;
        end
    end

endmodule

// File: rtl/izh_param_serializer.sv
// izh_param_serializer -- host-side transmitter for the Izhikevich neuron
// parameter load interface.
//
// On an accepted start the four parameter bytes are latched (a first), sent
// MSB-first on serial_data while load_mode frames them, and then the block
// waits for params_ready. done pulses on acknowledgement; error is a sticky
// timeout flag cleared by the next accepted start.
//
// Configuration macro: IZH_SER_PARITY_EN -- when defined, an even-parity
// bit follows each parameter's LSB and a frame is 36 bits instead of 32.
//
// Ports:
//   clk           in   system clock, rising edge
//   reset         in   asynchronous active-high reset
//   enable        in   clock enable; low freezes all state
//   start         in   frame request, sampled only in IDLE
//   param_a..d    in   parameter bytes, latched on an accepted start
//   params_ready  in   acknowledgement from the receiver
//   load_mode     out  high for the whole frame
//   serial_data   out  current serial bit
//   busy          out  high in every state except IDLE
//   done          out  one-cycle acknowledgement pulse (held while enable low)
//   error         out  sticky acknowledgement-timeout flag
module izh_param_serializer
    import izh_pkg::*;
#(
    parameter int BIT_DIV     = 4,
    parameter int ACK_TIMEOUT = 64
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enable,
    input  logic                   start,
    input  logic [IZH_PARAM_W-1:0] param_a,
    input  logic [IZH_PARAM_W-1:0] param_b,
    input  logic [IZH_PARAM_W-1:0] param_c,
    input  logic [IZH_PARAM_W-1:0] param_d,
    input  logic                   params_ready,
    output logic                   load_mode,
    output logic                   serial_data,
    output logic                   busy,
    output logic                   done,
    output logic                   error
);

`ifdef IZH_SER_PARITY_EN
    localparam bit PARITY_EN = 1'b1;
`else
    localparam bit PARITY_EN = 1'b0;
`endif

    localparam int                FRAME_BITS = izh_frame_bits(PARITY_EN);
    localparam int                IDX_W      = $clog2(FRAME_BITS);
    localparam logic [IDX_W-1:0]  LAST_IDX   = IDX_W'(FRAME_BITS - 1);
    localparam logic [15:0]       TO_LAST    = 16'(ACK_TIMEOUT - 1);

    izh_ser_state_t        state_q, state_d;
    logic [FRAME_BITS-1:0] sr_q, sr_d;
    logic [FRAME_BITS-1:0] frame_load;
    logic [15:0]           to_cnt_q, to_cnt_d;
    logic                  error_q, error_d;
    logic                  accept;
    logic                  bit_tick;
    logic [IDX_W-1:0]      bit_idx;

    // Frame image in line order: the MSB of the register goes out first.
`ifdef IZH_SER_PARITY_EN
    assign frame_load = {param_a, ^param_a, param_b, ^param_b,
                         param_c, ^param_c, param_d, ^param_d};
`else
    assign frame_load = {param_a, param_b, param_c, param_d};
`endif

    assign accept = enable && start && (state_q == ST_IDLE);

    izh_bit_timer #(
        .BIT_DIV (BIT_DIV),
        .IDX_W   (IDX_W)
    ) u_bit_timer (
        .clk      (clk),
        .reset    (reset),
        .enable   (enable),
        .load     (accept),
        .run      (state_q == ST_SHIFT),
        .bit_tick (bit_tick),
        .bit_idx  (bit_idx)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            sr_q     <= '0;
            to_cnt_q <= '0;
            error_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            sr_q     <= sr_d;
            to_cnt_q <= to_cnt_d;
            error_q  <= error_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        sr_d     = sr_q;
        to_cnt_d = to_cnt_q;
        error_d  = error_q;
        if (enable) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        sr_d     = frame_load;
                        error_d  = 1'b0;
                        to_cnt_d = '0;
                        state_d  = ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (bit_tick) begin
                        sr_d = sr_q << 1;
                        if (bit_idx == LAST_IDX) begin
                            to_cnt_d = '0;
                            state_d  = ST_WAIT_ACK;
                        end
                    end
                end
                ST_WAIT_ACK: begin
                    // error_q can only be set here by this frame's timeout
                    // (start clears it), so it marks the exit cycle: the flag
                    // is visible one cycle before busy drops. An ack in the
                    // cycle the count expires still wins.
                    if (error_q) begin
                        state_d = ST_IDLE;
                    end else if (params_ready) begin
                        state_d = ST_DONE;
                    end else begin
                        to_cnt_d = to_cnt_q + 16'd1;
                        if (to_cnt_q == TO_LAST) begin
                            error_d = 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // Outputs decode straight from state so an asynchronous reset clears
    // them without waiting for a clock edge.
    assign busy        = (state_q != ST_IDLE);
    assign load_mode   = (state_q == ST_SHIFT);
    assign serial_data = (state_q == ST_SHIFT) && sr_q[FRAME_BITS-1];
    assign done        = (state_q == ST_DONE);
    assign error       = error_q;

endmodule
